// File: rtl/fft_pkg.sv
// Shared FFT definitions: data/frame sizing, complex sample type, the
// bit-reversal helper and the reorder read-FSM state encoding.
package fft_pkg;

  localparam int DATA_W = 16;          // signed width of each real/imag component
  localparam int LOG2N  = 3;           // log2 of frame length
  localparam int N      = 1 << LOG2N;  // frame length

  typedef logic [LOG2N-1:0] idx_t;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_e;

  // Reverse the LOG2N index bits (frequency index <-> SDF output position).
  function automatic idx_t bitrev(input idx_t x);
    idx_t r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = x[LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_8_bitrev_reorder_if.sv
// Streaming bus of the bit-reversal reorder stage: bit-reversed input side
// and natural-order output side. No backpressure in either direction.
// Optional out_index signal is present when REORDER_INDEX_OUT_EN is defined.
interface fft_8_bitrev_reorder_if;
  import fft_pkg::*;

  logic                     in_valid;
  logic                     in_sync;
  logic signed [DATA_W-1:0] in_real;
  logic signed [DATA_W-1:0] in_imag;
  logic                     out_valid;
  logic                     out_first;
  logic                     out_last;
  logic signed [DATA_W-1:0] out_real;
  logic signed [DATA_W-1:0] out_imag;
`ifdef REORDER_INDEX_OUT_EN
  logic [LOG2N-1:0]         out_index;
`endif

  // Producer of the bit-reversed stream / consumer of the natural stream.
  modport master (
    output in_valid, in_sync, in_real, in_imag,
    input  out_valid, out_first, out_last, out_real, out_imag
`ifdef REORDER_INDEX_OUT_EN
    , input out_index
`endif
  );

  // The reorder stage itself.
  modport slave (
    input  in_valid, in_sync, in_real, in_imag,
    output out_valid, out_first, out_last, out_real, out_imag
`ifdef REORDER_INDEX_OUT_EN
    , output out_index
`endif
  );

endinterface

// File: rtl/fft_pingpong_ram.sv
// Two banks of N complex words addressed as {bank, index}; one write port
// and one registered read port.
module fft_pingpong_ram
  import fft_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  we,
  input  logic  wr_bank,
  input  idx_t  wr_addr,
  input  cplx_t wr_data,
  input  logic  re,
  input  logic  rd_bank,
  input  idx_t  rd_addr,
  output cplx_t rd_data
);

  cplx_t mem [2*N];
  cplx_t rd_data_q, rd_data_d;

  // Storage write.
  // NOTE: the array is deliberately not reset -- contents are only ever read
  // after being written, and a reset would prevent mapping onto RAM macros.
  always_ff @(posedge clk) begin
    if (we) mem[{wr_bank, wr_addr}] <= wr_data;
  end

  // Read data mux: hold the last word while no read is requested.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_data_d = rd_data_q;
    if (re) rd_data_d = mem[{rd_bank, rd_addr}];
  end

  // Registered read port, cleared so the outputs read 0 after reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_8_bitrev_reorder.sv
// Bit-reversal reorder stage after the 8-point SDF FFT. Frames arrive in
// bit-reversed order, are written by arrival count into one ping-pong bank
// and read out of the other bank at bitrev(rd_cnt), giving natural order.
// Optional: define REORDER_INDEX_OUT_EN to add the out_index output.
module fft_8_bitrev_reorder
  import fft_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  fft_8_bitrev_reorder_if.slave bus
);

  // Write side
  idx_t       wr_cnt_q, wr_cnt_d;
  logic       wr_bank_q, wr_bank_d;
  idx_t       wr_addr;
  logic       wr_wrap;
  // Bank-full flags, one per bank
  logic [1:0] full_q, full_d;
  // Read side
  rd_state_e  state_q, state_d;
  idx_t       rd_cnt_q, rd_cnt_d;
  logic       rd_bank_q, rd_bank_d;
  logic       rd_done;
  logic       rd_en;
  idx_t       rd_addr;
  // Registered output flags
  logic       out_valid_q, out_valid_d;
  logic       out_first_q, out_first_d;
  logic       out_last_q,  out_last_d;
`ifdef REORDER_INDEX_OUT_EN
  idx_t       out_index_q, out_index_d;
`endif
  cplx_t      rd_data;

  // Write addressing: sync restarts the current bank at 0, a completed frame
  // (address N-1 written) hands the bank over to the reader.
  always_comb begin
    wr_addr   = bus.in_sync ? '0 : wr_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    wr_wrap   = 1'b0;
    if (bus.in_valid) begin
      wr_cnt_d = wr_addr + idx_t'(1);
      wr_wrap  = (wr_addr == idx_t'(N-1));
      if (wr_wrap) wr_bank_d = ~wr_bank_q;
    end
  end

  // Full flags: set by the writer on frame completion, cleared by the reader
  // after its last sample. The two never address the same bank at once.
  always_comb begin
    full_d = full_q;
    if (rd_done) full_d[rd_bank_q] = 1'b0;
    if (wr_wrap) full_d[wr_bank_q] = 1'b1;
  end

  // Read FSM next state: start on the oldest full bank, run N cycles, then
  // chain straight into the other bank if it is already full.
  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    rd_done   = 1'b0;
    case (state_q)
      IDLE: begin
        rd_cnt_d = '0;
        if (full_q[rd_bank_q]) begin
          state_d = READ;
        end else if (full_q[~rd_bank_q]) begin
          state_d   = READ;
          rd_bank_d = ~rd_bank_q;
        end
      end
      READ: begin
        rd_cnt_d = rd_cnt_q + idx_t'(1);
        if (rd_cnt_q == idx_t'(N-1)) begin
          rd_done   = 1'b1;
          rd_bank_d = ~rd_bank_q;
          state_d   = full_q[~rd_bank_q] ? READ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read FSM outputs: RAM read request plus the flags registered alongside
  // the read data so they line up with it.
  always_comb begin
    rd_en       = (state_q == READ);
    rd_addr     = bitrev(rd_cnt_q);
    out_valid_d = rd_en;
    out_first_d = rd_en && (rd_cnt_q == '0);
    out_last_d  = rd_en && (rd_cnt_q == idx_t'(N-1));
`ifdef REORDER_INDEX_OUT_EN
    out_index_d = rd_en ? rd_cnt_q : '0;
`endif
  end

  // State register for write side, full flags, read FSM and output flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      full_q      <= '0;
      state_q     <= IDLE;
      rd_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef REORDER_INDEX_OUT_EN
      out_index_q <= '0;
`endif
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      full_q      <= full_d;
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_bank_q   <= rd_bank_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
`ifdef REORDER_INDEX_OUT_EN
      out_index_q <= out_index_d;
`endif
    end
  end

  fft_pingpong_ram u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (bus.in_valid & ~rst),
    .wr_bank (wr_bank_q),
    .wr_addr (wr_addr),
    .wr_data ({bus.in_real, bus.in_imag}),
    .re      (rd_en),
    .rd_bank (rd_bank_q),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign bus.out_valid = out_valid_q;
  assign bus.out_first = out_first_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_real  = rd_data.re;
  assign bus.out_imag  = rd_data.im;
`ifdef REORDER_INDEX_OUT_EN
  assign bus.out_index = out_index_q;
`endif

endmodule

// File: tb/tb_fft_8_bitrev_reorder.sv
// Self-checking bench for fft_8_bitrev_reorder: directed and randomized
// bit-reversed frames, compared cycle by cycle against a frame-level model
// that predicts every natural-order output sample and its arrival edge.
module tb_fft_8_bitrev_reorder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fft_8_bitrev_reorder_if bus ();

  fft_8_bitrev_reorder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int edge_cnt = 0;

  typedef struct {
    logic signed [15:0] re;
    logic signed [15:0] im;
    int                 idx;
    int                 due;
  } exp_t;

  exp_t               exp_q[$];
  exp_t               cur;
  logic               exp_valid;
  logic signed [15:0] frm_re [8];
  logic signed [15:0] frm_im [8];
  logic signed [15:0] nat_re [8];
  logic signed [15:0] nat_im [8];
  int                 frm_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_cnt, got, exp);
    end
  endtask

  // Sample arriving k-th in a frame carries frequency index with reversed bits.
  function automatic int freq_of_arrival(input int k);
    return ((k % 2) * 4) + (((k / 2) % 2) * 2) + ((k / 4) % 2);
  endfunction

  // Reference model: collect a frame by arrival, sort it into frequency
  // order, and schedule natural index n two edges plus n after completion.
  always @(posedge clk) begin
    edge_cnt++;
    if (rst) begin
      frm_cnt = 0;
      exp_q.delete();
    end else if (bus.in_valid) begin
      if (bus.in_sync) frm_cnt = 0;
      frm_re[frm_cnt] = bus.in_real;
      frm_im[frm_cnt] = bus.in_imag;
      frm_cnt++;
      if (frm_cnt == 8) begin
        for (int k = 0; k < 8; k++) begin
          nat_re[freq_of_arrival(k)] = frm_re[k];
          nat_im[freq_of_arrival(k)] = frm_im[k];
        end
        for (int n = 0; n < 8; n++) begin
          exp_q.push_back('{re: nat_re[n], im: nat_im[n], idx: n, due: edge_cnt + 2 + n});
        end
        frm_cnt = 0;
      end
    end
  end

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_valid = (exp_q.size() > 0) && (exp_q[0].due == edge_cnt);
    check("out_valid", bus.out_valid, exp_valid);
    if (exp_valid) begin
      cur = exp_q.pop_front();
      check("out_real",  bus.out_real,  cur.re);
      check("out_imag",  bus.out_imag,  cur.im);
      check("out_first", bus.out_first, cur.idx == 0);
      check("out_last",  bus.out_last,  cur.idx == 7);
`ifdef REORDER_INDEX_OUT_EN
      check("out_index", bus.out_index, cur.idx);
`endif
    end else begin
      check("idle_first", bus.out_first, 1'b0);
      check("idle_last",  bus.out_last,  1'b0);
    end
  end

  task automatic drive(input logic v, input logic s, input int r, input int i);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.in_sync  = s;
    bus.in_real  = 16'(r);
    bus.in_imag  = 16'(i);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, bus.out_valid, 1'b0);
    check({tag, "_first"}, bus.out_first, 1'b0);
    check({tag, "_last"},  bus.out_last,  1'b0);
    check({tag, "_real"},  bus.out_real,  32'(0));
    check({tag, "_imag"},  bus.out_imag,  32'(0));
`ifdef REORDER_INDEX_OUT_EN
    check({tag, "_index"}, bus.out_index, 32'(0));
`endif
  endtask

  initial begin
    int k;
    int guard;

    // Reset held for two edges while a synced sample is offered.
    bus.in_valid = 1'b1;
    bus.in_sync  = 1'b1;
    bus.in_real  = 16'sd55;
    bus.in_imag  = -16'sd3;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all_zero("reset");
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b0;

    // Single frame 100..107, imag = -k.
    for (int i = 0; i < 8; i++) drive(1'b1, i == 0, 100 + i, -i);
    idle(12);

    // Four back-to-back frames, real = 16*f+k, random imag.
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < 8; i++)
        drive(1'b1, i == 0, 16 * f + i, int'($urandom_range(0, 65535)));
    idle(12);

    // Gapped frame: valid every other cycle.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i == 0, 100 + i, -i);
      idle(1);
    end
    idle(12);

    // Mid-frame resync: partial frame of 5, then fresh frame 200..207.
    for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 300 + i, i);
    for (int i = 0; i < 8; i++) drive(1'b1, i == 0, 200 + i, -i - 1);
    idle(12);

    // Randomized frames with random gaps and occasional mid-frame resync.
    for (int f = 0; f < 8; f++) begin
      k = 0;
      while (k < 8) begin
        if ($urandom_range(0, 3) == 0) begin
          idle(1);
        end else if (k > 1 && $urandom_range(0, 15) == 0) begin
          drive(1'b1, 1'b1, int'($urandom), int'($urandom));
          k = 1;
        end else begin
          drive(1'b1, k == 0, int'($urandom), int'($urandom));
          k++;
        end
      end
    end
    idle(12);

    // Reset asserted while output sample 3 is on the bus.
    for (int i = 0; i < 8; i++) drive(1'b1, i == 0, 400 + i, i);
    idle(5);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midrst");
    rst = 1'b0;

    // Next frame after reset must come out intact.
    for (int i = 0; i < 8; i++) drive(1'b1, i == 0, 500 + i, 7 - i);
    idle(2);

    guard = 0;
    while (exp_q.size() > 0 && guard < 60) begin
      @(posedge clk);
      guard++;
    end
    check("drain", exp_q.size(), 32'(0));
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
